fetch_unit_buffered: RTL and testbench

//  Parametrised fetch stage: holds PC, drives a 1-cycle-latency synchronous instruction ROM,

---
 rtl/fetch_unit_buffered.sv | 134 +++++++++++++
 tb/tb_fetch_unit_buffered.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_buffered.sv
// fetch_unit_buffered
// Fetch stage: owns the PC, reads a 1-cycle-latency synchronous instruction ROM,
// queues returned words in a small FIFO and hands them to decode over valid/ready.
// Jump/branch redirects squash the in-flight read and flush every queued word.
module fetch_unit_buffered #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned INSTR_W   = 10,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_out
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    // PC and in-flight ROM read tracking
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;

    // Instruction FIFO storage and bookkeeping
    logic [INSTR_W-1:0] buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0]  buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Per-cycle control decisions
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect select, handshake, and credit-based issue decision
    always_comb begin
        redirect  = jump | branch;
        target    = jump ? jump_target : branch_addr;
        pop       = instr_valid & instr_ready;
        push      = inflight_q & ~redirect;
        // Words already queued plus the one on its way back, minus what decode takes now
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = ~reset & ~redirect & (occupancy < OCC_W'(BUF_DEPTH));
    end

    // ROM interface and FIFO head presentation
    always_comb begin
        imem_en     = issue;
        imem_addr   = pc_q;
        pc_out      = pc_q;
        instr_valid = (count_q != '0);
        instr       = buf_instr[rd_ptr_q];
        instr_pc    = buf_pc[rd_ptr_q];
    end

    // PC advance / redirect and in-flight read tag
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect) begin
                pc_q <= target;
            end else if (issue) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // FIFO: push returning ROM word, pop on handshake, flush on redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr_q] <= imem_rdata;
                buf_pc[wr_ptr_q]    <= inflight_pc_q;
                wr_ptr_q            <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A returning word must always find room; the credit check makes this impossible otherwise
    always_ff @(posedge clk) begin
        if (!reset && push && !pop) begin
            assert (count_q < CNT_W'(BUF_DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Testbench for fetch_unit_buffered: directed scenarios plus a randomized run,
// all delivered words checked against an instruction-stream reference model.
module tb_fetch_unit_buffered;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned INSTR_W   = 10;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned RESET_PC  = 0;

    logic               clk;
    logic               reset;
    logic               jump;
    logic               branch;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  branch_addr;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [ADDR_W-1:0]  pc_out;

    int errors = 0;
    int checks = 0;

    // Reference model state: address of the next word decode should receive
    logic [ADDR_W-1:0]  exp_pc;
    logic               hold_pending;
    logic [INSTR_W-1:0] held_instr;
    logic [ADDR_W-1:0]  held_pc;
    logic [ADDR_W-1:0]  last_popped_pc;
    logic               have_last;
    logic               saw_wrap;
    int                 pops;

    fetch_unit_buffered #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .jump(jump), .branch(branch),
        .jump_target(jump_target), .branch_addr(branch_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return INSTR_W'(int'(a) + 100);
    endfunction

    // Synchronous ROM with one-cycle read latency
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom_word(imem_addr);
    end

    // Stream scoreboard: in-order, gap-free delivery, stall stability, redirect restart
    always @(negedge clk) begin
        if (reset) begin
            exp_pc       = ADDR_W'(RESET_PC);
            hold_pending = 1'b0;
            have_last    = 1'b0;
        end else begin
            checks++;
            if (imem_addr !== pc_out) begin
                errors++;
                $display("FAIL imem_addr_eq_pc: imem_addr=%0d pc_out=%0d", imem_addr, pc_out);
            end
            if (hold_pending) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b instr=%0d pc=%0d expected valid=1 instr=%0d pc=%0d",
                             instr_valid, instr, instr_pc, held_instr, held_pc);
                end
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL stream_order: instr_pc=%0d instr=%0d expected pc=%0d instr=%0d",
                             instr_pc, instr, exp_pc, rom_word(exp_pc));
                end
                if (have_last && last_popped_pc == ADDR_W'((1 << ADDR_W) - 1) && instr_pc == '0)
                    saw_wrap = 1'b1;
                last_popped_pc = instr_pc;
                have_last      = 1'b1;
                exp_pc         = exp_pc + ADDR_W'(1);
                pops++;
            end
            hold_pending = instr_valid && !instr_ready && !jump && !branch;
            held_instr   = instr;
            held_pc      = instr_pc;
            if (jump) begin
                exp_pc    = jump_target;
                have_last = 1'b0;
            end else if (branch) begin
                exp_pc    = branch_addr;
                have_last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (pc_out !== ADDR_W'(RESET_PC) || instr_valid !== 1'b0 || imem_en !== 1'b0 ||
            instr !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d valid=%0b en=%0b instr=%0d ipc=%0d expected %0d/0/0/0/0",
                     pc_out, instr_valid, imem_en, instr, instr_pc, RESET_PC);
        end
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        reset       = 1'b0;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== ADDR_W'(RESET_PC)) begin
            errors++;
            $display("FAIL first_issue: en=%0b addr=%0d expected en=1 addr=%0d", imem_en, imem_addr, RESET_PC);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL startup_latency: valid=%0b one cycle after release, expected 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(RESET_PC) || instr !== rom_word(ADDR_W'(RESET_PC))) begin
            errors++;
            $display("FAIL first_word: valid=%0b pc=%0d instr=%0d expected 1/%0d/%0d",
                     instr_valid, instr_pc, instr, RESET_PC, rom_word(ADDR_W'(RESET_PC)));
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(RESET_PC + i)) begin
                errors++;
                $display("FAIL steady_stream: valid=%0b pc=%0d expected 1/%0d", instr_valid, instr_pc, RESET_PC + i);
            end
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (imem_en !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_fetch_stop: en=%0b valid=%0b expected en=0 valid=1", imem_en, instr_valid);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: valid=%0b expected 1", instr_valid);
        end
    endtask

    // Redirect then confirm the 3-cycle restart at the chosen target
    task automatic redirect_check(input string name, input logic j, input logic [ADDR_W-1:0] jt,
                                  input logic b, input logic [ADDR_W-1:0] ba,
                                  input logic [ADDR_W-1:0] want);
        jump = j; jump_target = jt; branch = b; branch_addr = ba;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_en_in_redirect: en=%0b expected 0", name, imem_en);
        end
        tick();
        jump = 1'b0; branch = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_flush_t%0d: valid=%0b expected 0", name, k, instr_valid);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(int'(want) + k) ||
                instr !== rom_word(ADDR_W'(int'(want) + k))) begin
                errors++;
                $display("FAIL %s_restart: valid=%0b pc=%0d instr=%0d expected 1/%0d/%0d", name,
                         instr_valid, instr_pc, instr, ADDR_W'(int'(want) + k),
                         rom_word(ADDR_W'(int'(want) + k)));
            end
            tick();
        end
    endtask

    task automatic test_branch();
        redirect_check("branch", 1'b0, '0, 1'b1, ADDR_W'(40), ADDR_W'(40));
    endtask

    task automatic test_jump_priority();
        redirect_check("jump_prio", 1'b1, ADDR_W'(500), 1'b1, ADDR_W'(40), ADDR_W'(500));
    endtask

    task automatic test_back_to_back();
        branch = 1'b1; branch_addr = ADDR_W'(200);
        tick();
        branch_addr = ADDR_W'(300);
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_mid_flush: valid=%0b expected 0", instr_valid);
        end
        redirect_check("b2b", 1'b0, '0, 1'b1, ADDR_W'(400), ADDR_W'(400));
    endtask

    task automatic test_wrap();
        saw_wrap = 1'b0;
        redirect_check("wrap", 1'b1, ADDR_W'(1020), 1'b0, '0, ADDR_W'(1020));
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: saw 1023->0 = %0b expected 1", saw_wrap);
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL prefill_full: valid=%0b en=%0b expected 1/0", instr_valid, imem_en);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc_out !== ADDR_W'(RESET_PC)) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b pc=%0d expected 0/%0d", instr_valid, pc_out, RESET_PC);
        end
        reset       = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(RESET_PC)) begin
            errors++;
            $display("FAIL post_reset_restart: valid=%0b pc=%0d expected 1/%0d", instr_valid, instr_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        int start_pops;
        int r;
        start_pops = pops;
        for (int i = 0; i < 3000; i++) begin
            r           = int'($urandom_range(0, 99));
            instr_ready = ($urandom_range(0, 3) != 0);
            jump        = (r < 3);
            branch      = (r >= 2 && r < 7);
            jump_target = ADDR_W'($urandom);
            branch_addr = ADDR_W'($urandom);
            tick();
        end
        jump = 1'b0; branch = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pops - start_pops < 1000) begin
            errors++;
            $display("FAIL random_throughput: pops=%0d expected at least 1000", pops - start_pops);
        end
    endtask

    initial begin
        reset = 1'b1; jump = 1'b0; branch = 1'b0; instr_ready = 1'b0;
        jump_target = '0; branch_addr = '0;
        pops = 0; saw_wrap = 1'b0; have_last = 1'b0; hold_pending = 1'b0;
        exp_pc = ADDR_W'(RESET_PC); last_popped_pc = '0;
        held_instr = '0; held_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_jump_priority();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
